shift_enable_fsm: RTL and testbench

//   One-shot shift-enable generator for a serial-config datapath.

---
 rtl/shift_fsm_pkg.sv | 16 +
 rtl/sat_down_counter.sv | 37 +++
 rtl/shift_enable_fsm.sv | 60 ++++++
 tb/tb_shift_enable_fsm.sv | 129 ++++++++++++
 4 files changed

// File: rtl/shift_fsm_pkg.sv
// Shared constants and state type for the one-shot shift-enable generator.
package shift_fsm_pkg;

    localparam int unsigned ENA_CYCLES_DEFAULT = 4;
    localparam int unsigned STATE_W = $clog2(ENA_CYCLES_DEFAULT + 1);

    // Encodes to 0..4; codes 5..7 are illegal and decode as StDone.
    typedef enum logic [STATE_W-1:0] {
        StB0,
        StB1,
        StB2,
        StB3,
        StDone
    } state_e;

endpackage

// File: rtl/sat_down_counter.sv
// Saturating down-counter: loads Load on reset and counts to zero.
// active_o is high while the count is in 1..Load.
module sat_down_counter #(
    parameter int unsigned Width = 3,
    parameter int unsigned Load  = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic active_o
);

    localparam logic [Width-1:0] LoadVal = Width'(Load);

    logic [Width-1:0] count_q, count_d;
    logic             in_range;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= LoadVal;
        end else begin
            count_q <= count_d;
        end
    end

    // Codes above Load cannot occur legally; collapse them to zero (idle).
    assign in_range = (count_q != '0) && (count_q <= LoadVal);

    always_comb begin
        count_d = '0;
        if (in_range) begin
            count_d = count_q - Width'(1);
        end
    end

    assign active_o = in_range;

endmodule

// File: rtl/shift_enable_fsm.sv
// One-shot shift enable: high for ENA_CYCLES cycles after each synchronous reset,
// then low until the next reset. Output is decoded from registered state only.
module shift_enable_fsm
    import shift_fsm_pkg::*;
#(
    parameter int unsigned ENA_CYCLES = ENA_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic shift_ena
);

    if (ENA_CYCLES == ENA_CYCLES_DEFAULT) begin : g_enum
        state_e state_q, state_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StB0;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = StDone;
            case (state_q)
                StB0:    state_d = StB1;
                StB1:    state_d = StB2;
                StB2:    state_d = StB3;
                StB3:    state_d = StDone;
                default: state_d = StDone;
            endcase
        end

        always_comb begin
            shift_ena = 1'b0;
            case (state_q)
                StB0, StB1, StB2, StB3: shift_ena = 1'b1;
                default:                shift_ena = 1'b0;
            endcase
        end
    end else begin : g_cnt
        // Non-default lengths use the counter encoding; timing matches the enum FSM.
        localparam int unsigned CntW = $clog2(ENA_CYCLES + 1);

        logic active;

        sat_down_counter #(
            .Width (CntW),
            .Load  (ENA_CYCLES)
        ) u_cnt (
            .clk_i    (clk),
            .reset_i  (reset),
            .active_o (active)
        );

        assign shift_ena = active;
    end

endmodule

// File: tb/tb_shift_enable_fsm.sv
// Bench for shift_enable_fsm at ENA_CYCLES = 4, 1 and 7 against a cycles-since-reset model.
module tb_shift_enable_fsm;

    logic clk;
    logic reset;
    logic ena4, ena1, ena7;

    int vectors;
    int miscompares;

    // Model: edges elapsed since the last edge that sampled reset=1.
    int since;
    bit valid;

    shift_enable_fsm #(.ENA_CYCLES(4)) u_dut4 (.clk(clk), .reset(reset), .shift_ena(ena4));
    shift_enable_fsm #(.ENA_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .shift_ena(ena1));
    shift_enable_fsm #(.ENA_CYCLES(7)) u_dut7 (.clk(clk), .reset(reset), .shift_ena(ena7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_check(input string where);
        if (valid) begin
            check({"model E=4 ", where}, ena4, logic'(since < 4));
            check({"model E=1 ", where}, ena1, logic'(since < 1));
            check({"model E=7 ", where}, ena7, logic'(since < 7));
        end
    endtask

    // Compare process: model advances on each posedge; outputs sampled after the
    // edge and again at negedge (reset has moved by then, exposing any comb path).
    initial begin
        since = 0;
        valid = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                since = 0;
                valid = 1'b1;
            end else if (since < 1000) begin
                since++;
            end
            #1;
            model_check("post-edge");
            @(negedge clk);
            model_check("negedge");
        end
    end

    // Drive reset for the next edge, then return 3 time units after that edge.
    task automatic cyc(input logic r);
        reset = r;
        @(posedge clk);
        #3;
    endtask

    initial begin
        logic [8:1] pin4, pin1, pin7;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        #2;

        // 1: reset held for 3 edges, then release.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            check("hold rst E=4", ena4, 1'b1);
            check("hold rst E=1", ena1, 1'b1);
            check("hold rst E=7", ena7, 1'b1);
        end
        pin4 = 8'b0000_0111;
        pin1 = 8'b0000_0000;
        pin7 = 8'b0011_1111;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0);
            check("release E=4", ena4, pin4[i]);
            check("release E=1", ena1, pin1[i]);
            check("release E=7", ena7, pin7[i]);
        end

        // 2: stays low in DONE.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0);
            check("done hold E=4", ena4, 1'b0);
        end

        // 3: 1-cycle reset two cycles into the window restarts the count.
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        check("restart edge E=4", ena4, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0);
            check("restart E=4", ena4, pin4[i]);
            check("restart E=7", ena7, pin7[i]);
        end

        // 4: 1-cycle reset while in DONE.
        for (int i = 0; i < 6; i++) cyc(1'b0);
        check("pre-pulse E=7", ena7, 1'b0);
        cyc(1'b1);
        check("pulse edge E=4", ena4, 1'b1);
        check("pulse edge E=1", ena1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0);
            check("pulse E=4", ena4, pin4[i]);
            check("pulse E=1", ena1, pin1[i]);
        end

        // 5: random sparse resets, checked by the compare process.
        for (int i = 0; i < 200; i++) begin
            cyc(logic'($urandom_range(31) == 0));
        end
        cyc(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
